// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply/divide unit producing the HI/LO pair.
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   start     begin an operation (accepted only when idle)
//   op        0 = signed multiply, 1 = signed divide (sampled with start)
//   a, b      operands (two's complement)
//   busy      operation in progress
//   done      one-cycle pulse; hi/lo valid from this cycle on
//   div_zero  set with done when a divide had b == 0; cleared at next accepted start
//   hi, lo    mult: product high/low halves; div: remainder/quotient
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StZero = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Shared accumulator: mult {A(W+1), Q(W)}; div {R(W+1), Q(W)}.
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH:0]     m_q, m_d;
    logic               qm1_q, qm1_d;
    logic               op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     booth_a;
    logic [2*WIDTH:0]   mul_step;
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH:0]   div_step;
    logic [WIDTH-1:0]   quo, rem;

    assign a_abs = a[WIDTH-1] ? -a : a;
    assign b_abs = b[WIDTH-1] ? -b : b;

    // Radix-2 Booth; A is one bit wider so that subtracting -2^(W-1) cannot overflow.
    always_comb begin
        booth_a = acc_q[2*WIDTH:WIDTH];
        unique case ({acc_q[0], qm1_q})
            2'b01:   booth_a = acc_q[2*WIDTH:WIDTH] + m_q;
            2'b10:   booth_a = acc_q[2*WIDTH:WIDTH] - m_q;
            default: booth_a = acc_q[2*WIDTH:WIDTH];
        endcase
    end
    assign mul_step = {booth_a[WIDTH], booth_a, acc_q[WIDTH-1:1]};

    // Restoring division on magnitudes: shift, trial-subtract, keep if non-negative.
    assign div_sh   = {acc_q[2*WIDTH-1:0], 1'b0};
    assign trial    = div_sh[2*WIDTH:WIDTH] - m_q;
    assign div_step = trial[WIDTH] ? div_sh : {trial, div_sh[WIDTH-1:1], 1'b1};

    assign quo = acc_q[WIDTH-1:0];
    assign rem = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d   = op;
                    sa_d   = a[WIDTH-1];
                    sb_d   = b[WIDTH-1];
                    dz_d   = 1'b0;
                    cnt_d  = '0;
                    qm1_d  = 1'b0;
                    busy_d = 1'b1;
                    if (op) begin
                        acc_d = {{(WIDTH+1){1'b0}}, a_abs};
                        m_d   = {1'b0, b_abs};
                    end else begin
                        acc_d = {{(WIDTH+1){1'b0}}, a};
                        m_d   = {b[WIDTH-1], b};
                    end
                    state_d = (op && (b == '0)) ? StZero : StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StFix;
                end
                if (op_q) begin
                    acc_d = div_step;
                end else begin
                    acc_d = mul_step;
                    qm1_d = acc_q[0];
                end
            end
            StFix: begin
                if (op_q) begin
                    // Magnitude quotient of -2^(W-1) / -1 is 2^(W-1), which wraps naturally.
                    lo_d = (sa_q ^ sb_q) ? -quo : quo;
                    hi_d = sa_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = acc_q[2*WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StZero: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dz_d    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            op_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (WIDTH = 32).
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: 64-bit signed arithmetic, truncating division.
    task automatic push_expected(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
        longint q;
        longint r;
        exp_t   e;
        e.dz = 1'b0;
        if (!o) begin
            p = longint'($signed(x)) * longint'($signed(y));
            model_hi = p[63:32];
            model_lo = p[31:0];
        end else if (y == '0) begin
            e.dz = 1'b1;
        end else begin
            q = longint'($signed(x)) / longint'($signed(y));
            r = longint'($signed(x)) % longint'($signed(y));
            model_hi = r[31:0];
            model_lo = q[31:0];
        end
        e.hi = model_hi;
        e.lo = model_lo;
        sb_q.push_back(e);
    endtask

    // Drives start for edge E0 and returns just after E0.
    task automatic launch(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit hold);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        push_expected(o, x, y);
        step();
        if (!hold) start = 1'b0;
    endtask

    // Edges until done is seen (-1 on timeout); counts busy samples on the way.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = -1;
        busy_cycles = 0;
        for (int i = 1; i <= 100; i++) begin
            if (busy) busy_cycles++;
            step();
            if (done) begin
                edges = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) step();
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero});
        end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++;
            $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_mult();
        logic [W-1:0] xs[7];
        logic [W-1:0] ys[7];
        int           edges;
        int           bc;
        exp_t         e;
        xs = '{32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0};
        ys = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0};
        for (int i = 5; i < 7; i++) begin
            xs[i] = $urandom;
            ys[i] = $urandom;
        end
        for (int i = 0; i < 7; i++) begin
            launch(1'b0, xs[i], ys[i], 1'b0);
            wait_done(edges, bc);
            e = sb_q.pop_front();
            checks++;
            if (edges != W + 1) begin
                errors++;
                $display("FAIL mult_latency[%0d]: got %0d expected %0d", i, edges, W + 1);
            end
            if (i == 0) begin
                checks++;
                if (bc != W + 1) begin
                    errors++;
                    $display("FAIL mult_busy_cycles: got %0d expected %0d", bc, W + 1);
                end
            end
            checks++;
            if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
                errors++;
                $display("FAIL mult_result[%0d] %h*%h: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                         i, xs[i], ys[i], hi, lo, div_zero, e.hi, e.lo, e.dz);
            end
            step();
            checks++;
            if (done !== 1'b0 || {hi, lo} !== {e.hi, e.lo}) begin
                errors++;
                $display("FAIL mult_hold[%0d]: got done=%b hi=%h lo=%h expected done=0 hi=%h lo=%h",
                         i, done, hi, lo, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] xs[7];
        logic [W-1:0] ys[7];
        int           edges;
        int           bc;
        exp_t         e;
        xs = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd100, 32'hFFFF_FF9C, 32'd0, 32'd0};
        ys = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'd0};
        for (int i = 5; i < 7; i++) begin
            xs[i] = $urandom;
            ys[i] = $urandom_range(1, 1000);
            if (i == 6) ys[i] = -ys[i];
        end
        for (int i = 0; i < 7; i++) begin
            launch(1'b1, xs[i], ys[i], 1'b0);
            wait_done(edges, bc);
            e = sb_q.pop_front();
            checks++;
            if (edges != W + 1) begin
                errors++;
                $display("FAIL div_latency[%0d]: got %0d expected %0d", i, edges, W + 1);
            end
            checks++;
            if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
                errors++;
                $display("FAIL div_result[%0d] %h/%h: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                         i, xs[i], ys[i], hi, lo, div_zero, e.hi, e.lo, e.dz);
            end
            step();
        end
    endtask

    task automatic test_div_zero();
        int   edges;
        int   bc;
        exp_t e;
        launch(1'b1, 32'd5, 32'd0, 1'b0);
        wait_done(edges, bc);
        e = sb_q.pop_front();
        checks++;
        if (edges != 1) begin
            errors++;
            $display("FAIL divzero_latency: got %0d expected 1", edges);
        end
        checks++;
        if ({hi, lo, div_zero} !== {e.hi, e.lo, 1'b1}) begin
            errors++;
            $display("FAIL divzero_result: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=1",
                     hi, lo, div_zero, e.hi, e.lo);
        end
        repeat (3) step();
        checks++;
        if (div_zero !== 1'b1) begin
            errors++;
            $display("FAIL divzero_sticky: got %b expected 1", div_zero);
        end
        launch(1'b0, 32'd3, 32'd4, 1'b0);
        wait_done(edges, bc);
        e = sb_q.pop_front();
        checks++;
        if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
            errors++;
            $display("FAIL divzero_clear: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                     hi, lo, div_zero, e.hi, e.lo, e.dz);
        end
        step();
    endtask

    task automatic test_mid_run();
        int   edges;
        int   bc;
        int   seen;
        exp_t e;
        launch(1'b0, 32'd11, 32'hFFFF_FFF3, 1'b0);
        repeat (4) step();
        // Intruding start sampled at E5 must be ignored.
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd99;
        b     = 32'd0;
        step();
        start = 1'b0;
        wait_done(edges, bc);
        e = sb_q.pop_front();
        checks++;
        if (edges != W + 1 - 5) begin
            errors++;
            $display("FAIL midstart_latency: got %0d expected %0d", edges, W + 1 - 5);
        end
        checks++;
        if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
            errors++;
            $display("FAIL midstart_result: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                     hi, lo, div_zero, e.hi, e.lo, e.dz);
        end
        step();
        launch(1'b0, 32'd123, 32'd456, 1'b0);
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb_q.delete();
        model_hi = '0;
        model_lo = '0;
        checks++;
        if ({busy, done, div_zero, hi, lo} !== {3'b000, 64'd0}) begin
            errors++;
            $display("FAIL midreset_state: got busy=%b done=%b dz=%b hi=%h lo=%h expected all 0",
                     busy, done, div_zero, hi, lo);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) seen++;
        end
        checks++;
        if (seen != 0 || {hi, lo} !== 64'd0) begin
            errors++;
            $display("FAIL midreset_nodone: got %0d pulses hi=%h lo=%h expected 0 pulses, 0",
                     seen, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int   edges;
        int   bc;
        exp_t e;
        launch(1'b0, 32'd6, 32'd7, 1'b1);
        // Operands change after E0; start stays high through done.
        op = 1'b1;
        a  = 32'hFFFF_FFF7;
        b  = 32'd4;
        push_expected(1'b1, 32'hFFFF_FFF7, 32'd4);
        wait_done(edges, bc);
        e = sb_q.pop_front();
        checks++;
        if (edges != W + 1 || {hi, lo} !== {e.hi, e.lo}) begin
            errors++;
            $display("FAIL b2b_first: got edges=%0d hi=%h lo=%h expected edges=%0d hi=%h lo=%h",
                     edges, hi, lo, W + 1, e.hi, e.lo);
        end
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got done=%b busy=%b expected done=0 busy=1", done, busy);
        end
        wait_done(edges, bc);
        e = sb_q.pop_front();
        checks++;
        if (edges != W + 1 || {hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
            errors++;
            $display("FAIL b2b_second: got edges=%0d hi=%h lo=%h dz=%b expected edges=%0d hi=%h lo=%h dz=%b",
                     edges, hi, lo, div_zero, W + 1, e.hi, e.lo, e.dz);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
